// File: rtl/regfile_wb_queue.sv
// In-order writeback queue in front of the register file write port.
// Pending results are forwarded to both decode read ports until committed.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     wr_hold,
    output logic                     wrEn,
    output logic [AW-1:0]            wrAddr,
    output logic [DW-1:0]            wrData,
    input  logic [AW-1:0]            rdAddr1,
    input  logic [AW-1:0]            rdAddr2,
    input  logic [DW-1:0]            rfData1,
    input  logic [DW-1:0]            rfData2,
    output logic [DW-1:0]            fwdData1,
    output logic [DW-1:0]            fwdData2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          empty;
    logic          push;
    logic          pop;

    assign empty    = (count == '0);
    assign wrEn     = ~empty & ~wr_hold;
    assign in_ready = (count != FULL) | ~wr_hold;
    assign push     = in_valid & in_ready;
    assign pop      = wrEn;
    assign wrAddr   = empty ? '0 : addr_q[rd_ptr];
    assign wrData   = empty ? '0 : data_q[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Full push+pop writes the slot being drained; the old head leaves on the same edge.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= in_addr;
            data_q[wr_ptr] <= in_data;
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwdData1 = rfData1;
        fwdData2 = rfData2;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((PW+1)'(i) < count) begin
                if (addr_q[idx] == rdAddr1)
                    fwdData1 = data_q[idx];
                if (addr_q[idx] == rdAddr2)
                    fwdData2 = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized and directed bench for regfile_wb_queue.
// Reference model: queue of pending writes plus a model register file.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int VW    = 3 + 2 + AW + 3 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          wr_hold = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] rdAddr1 = '0;
    logic [AW-1:0] rdAddr2 = '0;
    logic [DW-1:0] rfData1;
    logic [DW-1:0] rfData2;
    logic          in_ready;
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic [DW-1:0] fwdData1;
    logic [DW-1:0] fwdData2;
    logic [2:0]    count;

    regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .wr_hold(wr_hold),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddr1(rdAddr1), .rdAddr2(rdAddr2),
        .rfData1(rfData1), .rfData2(rfData2),
        .fwdData1(fwdData1), .fwdData2(fwdData2),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq [$];
    logic [DW-1:0] ref_rf [32];
    logic [DW-1:0] rf [32];
    int            total = 0;
    int            passed = 0;

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // Environment register file, written only by the DUT's write port.
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (wrEn) rf[wrAddr] <= wrData;
        end
    end

    assign rfData1 = rf[rdAddr1];
    assign rfData2 = rf[rdAddr2];

    function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] ra);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == ra) return mq[i].d;
        return ref_rf[ra];
    endfunction

    function automatic logic exp_wren();
        return mq.size() != 0 && !wr_hold;
    endfunction

    function automatic logic exp_ready();
        return mq.size() < DEPTH || !wr_hold;
    endfunction

    function automatic logic [VW-1:0] model_outs();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        ea = '0;
        ed = '0;
        if (mq.size() != 0) begin
            ea = mq[0].a;
            ed = mq[0].d;
        end
        return {3'(mq.size()), exp_wren(), exp_ready(), ea, ed,
                exp_fwd(rdAddr1), exp_fwd(rdAddr2)};
    endfunction

    wire [VW-1:0] dut_outs = {count, wrEn, in_ready, wrAddr, wrData,
                              fwdData1, fwdData2};

    task automatic tick();
        bit   pu;
        bit   po;
        ent_t e;
        pu = in_valid && exp_ready();
        po = exp_wren();
        e  = '{a: in_addr, d: in_data};
        @(posedge clk);
        if (po) begin
            ref_rf[mq[0].a] = mq[0].d;
            mq.delete(0);
        end
        if (pu) mq.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        rdAddr1 = 5'd7;
        #2 rst = 1'b1;
        mq.delete();
        #1;
        total++;
        if ({count, wrEn, in_ready} !== {3'd0, 1'b0, 1'b1})
            $display("FAIL reset_state got cnt=%0d en=%b rdy=%b want 0/0/1",
                     count, wrEn, in_ready);
        else passed++;
        total++;
        if (fwdData1 !== ref_rf[7])
            $display("FAIL reset_passthru got %h want %h", fwdData1, ref_rf[7]);
        else passed++;
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rdAddr1  = 5'd3;
        wr_hold  = 1'b0;
        in_valid = 1'b1;
        in_addr  = 5'd3;
        in_data  = 32'hDEAD_BEEF;
        #1;
        total++;
        if (fwdData1 !== init_val(3))
            $display("FAIL single_nofwd_arrival got %h want %h",
                     fwdData1, init_val(3));
        else passed++;
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if ({count, wrEn, wrAddr, wrData, fwdData1} !==
            {3'd1, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF})
            $display("FAIL single_head got c=%0d en=%b a=%0d d=%h f=%h",
                     count, wrEn, wrAddr, wrData, fwdData1);
        else passed++;
        tick();
        total++;
        if ({count, wrEn, wrAddr, wrData, rf[3]} !==
            {3'd0, 1'b0, 5'd0, 32'd0, 32'hDEAD_BEEF})
            $display("FAIL single_commit got c=%0d en=%b a=%0d d=%h rf3=%h",
                     count, wrEn, wrAddr, wrData, rf[3]);
        else passed++;
    endtask

    task automatic test_waw();
        wr_hold  = 1'b1;
        rdAddr2  = 5'd5;
        in_valid = 1'b1;
        in_addr  = 5'd5;
        in_data  = 32'h11;
        tick();
        in_data  = 32'h22;
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if ({count, wrEn, fwdData2} !== {3'd2, 1'b0, 32'h22})
            $display("FAIL waw_fwd got c=%0d en=%b f=%h want 2/0/22",
                     count, wrEn, fwdData2);
        else passed++;
        wr_hold = 1'b0;
        #1;
        total++;
        if ({wrEn, wrAddr, wrData} !== {1'b1, 5'd5, 32'h11})
            $display("FAIL waw_first got en=%b a=%0d d=%h want 1/5/11",
                     wrEn, wrAddr, wrData);
        else passed++;
        tick();
        total++;
        if ({wrEn, wrData, fwdData2, rf[5]} !== {1'b1, 32'h22, 32'h22, 32'h11})
            $display("FAIL waw_second got en=%b d=%h f=%h rf5=%h",
                     wrEn, wrData, fwdData2, rf[5]);
        else passed++;
        tick();
        total++;
        if ({count, rf[5], fwdData2} !== {3'd0, 32'h22, 32'h22})
            $display("FAIL waw_final got c=%0d rf5=%h f=%h want 0/22/22",
                     count, rf[5], fwdData2);
        else passed++;
    endtask

    task automatic test_full();
        wr_hold  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_addr = 5'(8 + i);
            in_data = $urandom;
            tick();
        end
        in_addr = 5'd12;
        in_data = 32'hF00D_0001;
        #1;
        total++;
        if ({count, in_ready, wrEn} !== {3'd4, 1'b0, 1'b0})
            $display("FAIL full_state got c=%0d rdy=%b en=%b want 4/0/0",
                     count, in_ready, wrEn);
        else passed++;
        tick();
        total++;
        if (dut_outs !== model_outs())
            $display("FAIL full_blocked got %h want %h", dut_outs, model_outs());
        else passed++;
        wr_hold = 1'b0;
        #1;
        total++;
        if ({in_ready, wrEn, wrAddr} !== {1'b1, 1'b1, 5'd8})
            $display("FAIL full_pushpop got rdy=%b en=%b a=%0d want 1/1/8",
                     in_ready, wrEn, wrAddr);
        else passed++;
        tick();
        total++;
        if ({count, wrAddr} !== {3'd4, 5'd9})
            $display("FAIL full_stays got c=%0d a=%0d want 4/9", count, wrAddr);
        else passed++;
        in_valid = 1'b0;
        for (int i = 0; i < 10 && mq.size() != 0; i++) tick();
        total++;
        if (count !== 3'd0 || mq.size() != 0)
            $display("FAIL full_drain got c=%0d model=%0d want 0",
                     count, mq.size());
        else passed++;
    endtask

    task automatic test_drain_wrap();
        int bad;
        wr_hold = 1'b0;
        rdAddr1 = 5'd16;
        rdAddr2 = 5'd17;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_addr  = 5'(16 + i);
            in_data  = $urandom;
            #1;
            total++;
            if (dut_outs !== model_outs())
                $display("FAIL wrap_cyc%0d got %h want %h",
                         i, dut_outs, model_outs());
            else passed++;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8 && mq.size() != 0; i++) tick();
        bad = 0;
        for (int i = 0; i < 32; i++) if (rf[i] !== ref_rf[i]) bad++;
        total++;
        if (count !== 3'd0 || bad != 0)
            $display("FAIL wrap_commit got c=%0d badregs=%0d want 0/0",
                     count, bad);
        else passed++;
    endtask

    task automatic test_reset_pending();
        int wrote;
        wr_hold  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_addr = 5'(20 + i);
            in_data = 32'hC0DE_0000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        rdAddr1  = 5'd21;
        #2 rst = 1'b1;
        mq.delete();
        #1;
        total++;
        if ({count, wrEn, in_ready, fwdData1} !==
            {3'd0, 1'b0, 1'b1, ref_rf[21]})
            $display("FAIL rstpend_state got c=%0d en=%b rdy=%b f=%h",
                     count, wrEn, in_ready, fwdData1);
        else passed++;
        @(negedge clk) rst = 1'b0;
        wr_hold = 1'b0;
        wrote = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (wrEn) wrote++;
            tick();
        end
        total++;
        if (wrote != 0 || rf[20] !== ref_rf[20] || rf[22] !== ref_rf[22])
            $display("FAIL rstpend_nowrite got writes=%0d rf20=%h want 0/%h",
                     wrote, rf[20], ref_rf[20]);
        else passed++;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            wr_hold  = ($urandom_range(0, 3) == 0);
            in_addr  = ($urandom_range(0, 9) == 0) ? 5'd31
                                                   : 5'($urandom_range(0, 7));
            in_data  = $urandom;
            rdAddr1  = 5'($urandom_range(0, 7));
            rdAddr2  = ($urandom_range(0, 5) == 0) ? 5'd31
                                                   : 5'($urandom_range(0, 7));
            #1;
            total++;
            if (dut_outs !== model_outs())
                $display("FAIL rand_cyc%0d got %h want %h",
                         c, dut_outs, model_outs());
            else passed++;
            tick();
        end
        in_valid = 1'b0;
        wr_hold  = 1'b0;
        for (int i = 0; i < 8 && mq.size() != 0; i++) tick();
        for (int i = 0; i < 32; i++) if (rf[i] !== ref_rf[i]) bad++;
        total++;
        if (count !== 3'd0 || bad != 0)
            $display("FAIL rand_regfile got c=%0d badregs=%0d want 0/0",
                     count, bad);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_rf[i] = init_val(i);
        test_reset();
        test_single();
        test_waw();
        test_full();
        test_drain_wrap();
        test_reset_pending();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
